// File: rtl/codec_arith_pkg.sv
// Shared definitions for the arithmetic-codec divider path: default widths,
// arbiter state encoding and the requester index type.
package codec_arith_pkg;

    localparam int unsigned CODEC_PRECISION  = 16;
    localparam int unsigned CODEC_DIVIDEND_W = 2 * CODEC_PRECISION - 2;
    localparam int unsigned CODEC_DIVISOR_W  = CODEC_PRECISION - 2;

    // Largest supported client count; the index type is sized for it.
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned REQ_IDX_W = $clog2(MAX_REQ);

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // (base + off) mod num_req, valid for base < num_req and off < num_req.
    function automatic req_idx_t wrap_add(req_idx_t base, int unsigned off, int unsigned num_req);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= num_req) begin
            sum = sum - num_req;
        end
        return req_idx_t'(sum);
    endfunction

endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding the issuing client of each in-flight division.
// Head is presented combinationally; push when full and pop when empty are ignored.
module tag_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_c,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full_c    = (count_q == CNT_W'(DEPTH));
    assign empty_c   = (count_q == '0);
    assign push_ok_c = push_i && !full_c;
    assign pop_ok_c  = pop_i && !empty_c;
    assign head_c    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok_c, pop_ok_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one pipelined AXI-Stream divider among NUM_REQ codec
// clients; quotients are routed back in issue order via a tag FIFO.
module divider_arbiter
    import codec_arith_pkg::*;
#(
    parameter int unsigned PRECISION       = CODEC_PRECISION,
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned DIVIDEND_W      = 2 * PRECISION - 2,
    parameter int unsigned DIVISOR_W       = PRECISION - 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DIVIDEND_W-1:0]   req_dividend,
    input  logic [NUM_REQ*DIVISOR_W-1:0]    req_divisor,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DIVIDEND_W-1:0]           rsp_quotient,
    output logic                            divisor_tvalid,
    input  logic                            divisor_tready,
    output logic [DIVISOR_W-1:0]            divisor_tdata,
    output logic                            dividend_tvalid,
    input  logic                            dividend_tready,
    output logic [DIVIDEND_W-1:0]           dividend_tdata,
    input  logic                            dout_tvalid,
    input  logic [DIVIDEND_W-1:0]           dout_tdata,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                            err_orphan
);

    localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e             state_q;
    req_idx_t               rr_q;
    logic [NUM_REQ-1:0]     req_ready_q;
    logic                   dvs_tvalid_q;
    logic                   dvd_tvalid_q;
    logic [DIVISOR_W-1:0]   dvs_tdata_q;
    logic [DIVIDEND_W-1:0]  dvd_tdata_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [DIVIDEND_W-1:0]  rsp_quotient_q;
    logic                   err_orphan_q;

    logic [MAX_REQ-1:0]     req_valid_ext_c;
    req_idx_t               grant_c;
    logic                   any_req_c;
    logic [NUM_REQ-1:0]     grant_oh_c;
    logic [DIVISOR_W-1:0]   sel_divisor_c;
    logic [DIVIDEND_W-1:0]  sel_dividend_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   dvs_pend_c;
    logic                   dvd_pend_c;
    logic [TAG_W-1:0]       head_c;
    req_idx_t               head_idx_c;
    logic [NUM_REQ-1:0]     head_oh_c;
    logic [CNT_W-1:0]       fifo_count_c;
    logic                   fifo_full_c;
    logic                   fifo_empty_c;

    assign req_valid_ext_c = MAX_REQ'(req_valid);

    // First requesting client at or after rr_q; lowest offset is applied last so it wins.
    always_comb begin
        grant_c   = '0;
        any_req_c = 1'b0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (req_valid_ext_c[wrap_add(rr_q, 32'(k), NUM_REQ)]) begin
                grant_c   = wrap_add(rr_q, 32'(k), NUM_REQ);
                any_req_c = 1'b1;
            end
        end
    end

    always_comb begin
        sel_divisor_c  = '0;
        sel_dividend_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (req_idx_t'(i) == grant_c) begin
                sel_divisor_c  = req_divisor[i*DIVISOR_W +: DIVISOR_W];
                sel_dividend_c = req_dividend[i*DIVIDEND_W +: DIVIDEND_W];
            end
        end
    end

    assign grant_oh_c = NUM_REQ'(MAX_REQ'(1) << grant_c);
    assign head_idx_c = req_idx_t'(head_c);
    assign head_oh_c  = NUM_REQ'(MAX_REQ'(1) << head_idx_c);

    assign push_c     = (state_q == ARB) && any_req_c && !fifo_full_c;
    assign pop_c      = dout_tvalid && !fifo_empty_c;
    assign dvs_pend_c = dvs_tvalid_q && !divisor_tready;
    assign dvd_pend_c = dvd_tvalid_q && !dividend_tready;

    tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (push_c),
        .push_data_i (TAG_W'(grant_c)),
        .pop_i       (pop_c),
        .head_c      (head_c),
        .count_o     (fifo_count_c),
        .full_c      (fifo_full_c),
        .empty_c     (fifo_empty_c)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= ARB;
            rr_q           <= '0;
            req_ready_q    <= '0;
            dvs_tvalid_q   <= 1'b0;
            dvd_tvalid_q   <= 1'b0;
            dvs_tdata_q    <= '0;
            dvd_tdata_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_quotient_q <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            rsp_valid_q <= '0;

            // Divider is in order, so the FIFO head owns every returning quotient.
            if (dout_tvalid) begin
                rsp_quotient_q <= dout_tdata;
                if (fifo_empty_c) begin
                    err_orphan_q <= 1'b1;
                end else begin
                    rsp_valid_q <= head_oh_c;
                end
            end

            case (state_q)
                ARB: begin
                    if (push_c) begin
                        req_ready_q  <= grant_oh_c;
                        dvs_tdata_q  <= sel_divisor_c;
                        dvd_tdata_q  <= sel_dividend_c;
                        dvs_tvalid_q <= 1'b1;
                        dvd_tvalid_q <= 1'b1;
                        rr_q         <= wrap_add(grant_c, 1, NUM_REQ);
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dvs_tvalid_q && divisor_tready) begin
                        dvs_tvalid_q <= 1'b0;
                    end
                    if (dvd_tvalid_q && dividend_tready) begin
                        dvd_tvalid_q <= 1'b0;
                    end
                    if (!dvs_pend_c && !dvd_pend_c) begin
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign divisor_tvalid  = dvs_tvalid_q;
    assign divisor_tdata   = dvs_tdata_q;
    assign dividend_tvalid = dvd_tvalid_q;
    assign dividend_tdata  = dvd_tdata_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_quotient    = rsp_quotient_q;
    assign outstanding     = fifo_count_c;
    assign err_orphan      = err_orphan_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural 3-cycle in-order divider.
module tb_divider_arbiter;

    localparam int unsigned NR    = 2;
    localparam int unsigned DW    = 30;
    localparam int unsigned SW    = 14;
    localparam int unsigned CW    = 4;
    localparam int unsigned LAT   = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_dividend;
    logic [NR*SW-1:0]  req_divisor;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_quotient;
    logic              divisor_tvalid;
    logic              divisor_tready;
    logic [SW-1:0]     divisor_tdata;
    logic              dividend_tvalid;
    logic              dividend_tready;
    logic [DW-1:0]     dividend_tdata;
    logic              dout_tvalid;
    logic [DW-1:0]     dout_tdata;
    logic [CW-1:0]     outstanding;
    logic              err_orphan;

    int checks = 0;
    int errors = 0;

    divider_arbiter #(
        .PRECISION       (16),
        .NUM_REQ         (NR),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .rsp_valid       (rsp_valid),
        .rsp_quotient    (rsp_quotient),
        .divisor_tvalid  (divisor_tvalid),
        .divisor_tready  (divisor_tready),
        .divisor_tdata   (divisor_tdata),
        .dividend_tvalid (dividend_tvalid),
        .dividend_tready (dividend_tready),
        .dividend_tdata  (dividend_tdata),
        .dout_tvalid     (dout_tvalid),
        .dout_tdata      (dout_tdata),
        .outstanding     (outstanding),
        .err_orphan      (err_orphan)
    );

    always #5 clk = ~clk;

    // ---------------- divider model ----------------
    logic [DW-1:0] res_q [$];
    int            due_q [$];
    int            cyc = 0;
    logic [SW-1:0] m_dvs;
    logic [DW-1:0] m_dvd;
    logic          got_dvs;
    logic          got_dvd;
    logic          hold_results;
    int            orphan_req = 0;
    int            orphan_done = 0;
    logic          hs_s;
    logic          hs_d;
    logic [SW-1:0] cur_dvs;
    logic [DW-1:0] cur_dvd;

    assign hs_s    = divisor_tvalid && divisor_tready;
    assign hs_d    = dividend_tvalid && dividend_tready;
    assign cur_dvs = hs_s ? divisor_tdata : m_dvs;
    assign cur_dvd = hs_d ? dividend_tdata : m_dvd;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            res_q.delete();
            due_q.delete();
            got_dvs     <= 1'b0;
            got_dvd     <= 1'b0;
            dout_tvalid <= 1'b0;
            dout_tdata  <= '0;
            orphan_done <= orphan_req;
        end else begin
            if (hs_s) m_dvs <= divisor_tdata;
            if (hs_d) m_dvd <= dividend_tdata;
            if ((got_dvs || hs_s) && (got_dvd || hs_d)) begin
                res_q.push_back(cur_dvd / DW'(cur_dvs));
                due_q.push_back(cyc + LAT);
                got_dvs <= 1'b0;
                got_dvd <= 1'b0;
            end else begin
                if (hs_s) got_dvs <= 1'b1;
                if (hs_d) got_dvd <= 1'b1;
            end
            if (orphan_req != orphan_done) begin
                dout_tvalid <= 1'b1;
                dout_tdata  <= DW'(123);
                orphan_done <= orphan_done + 1;
            end else if (!hold_results && res_q.size() > 0 && due_q[0] <= cyc) begin
                dout_tvalid <= 1'b1;
                dout_tdata  <= res_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                dout_tvalid <= 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_client(input int i, input int dvd, input int dvs);
        req_dividend[i*DW +: DW] = DW'(dvd);
        req_divisor[i*SW +: SW]  = SW'(dvs);
    endtask

    // Round-robin table: grant k belongs to client k%2.
    int rr_dvd [6] = '{1000, 999, 5000, 7777, 123456, 65536};
    int rr_dvs [6] = '{7, 3, 9, 11, 100, 256};
    int rr_quo [6] = '{142, 333, 555, 707, 1234, 256};

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_ready, divisor_tvalid, dividend_tvalid, rsp_valid} !== '0) begin
            errors++;
            $display("FAIL reset_valids: got %b required 0", {req_ready, divisor_tvalid, dividend_tvalid, rsp_valid});
        end
        rstn = 1'b1;
        tick();
        checks++;
        if (outstanding !== 4'd0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: outstanding=%0d err_orphan=%b required 0/0", outstanding, err_orphan);
        end
        checks++;
        if (rsp_quotient !== '0 || divisor_tdata !== '0 || dividend_tdata !== '0) begin
            errors++;
            $display("FAIL reset_data: quotient=%0d dvs=%0d dvd=%0d required 0", rsp_quotient, divisor_tdata, dividend_tdata);
        end
    endtask

    task automatic test_single();
        bit found = 0;
        set_client(0, 1000, 7);
        req_valid = 2'b01;
        tick();
        checks++;
        if (req_ready !== 2'b01 || {divisor_tvalid, dividend_tvalid} !== 2'b11) begin
            errors++;
            $display("FAIL single_grant: ready=%b tvalids=%b required 01/11", req_ready, {divisor_tvalid, dividend_tvalid});
        end
        checks++;
        if (divisor_tdata !== SW'(7) || dividend_tdata !== DW'(1000) || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL single_issue: dvs=%0d dvd=%0d outst=%0d required 7/1000/1", divisor_tdata, dividend_tdata, outstanding);
        end
        req_valid = 2'b00;
        tick();
        checks++;
        if (req_ready !== 2'b00 || {divisor_tvalid, dividend_tvalid} !== 2'b00) begin
            errors++;
            $display("FAIL single_drop: ready=%b tvalids=%b required 00/00", req_ready, {divisor_tvalid, dividend_tvalid});
        end
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (rsp_valid !== 2'b00) found = 1;
        end
        checks++;
        if (!found || rsp_valid !== 2'b01 || rsp_quotient !== DW'(142)) begin
            errors++;
            $display("FAIL single_rsp: found=%0d rsp=%b q=%0d required 01/142", found, rsp_valid, rsp_quotient);
        end
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL single_outst: got %0d required 0", outstanding);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_pulse: rsp=%b required 00", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int n [2];
        int gk = 0;
        int rk = 0;
        int g;
        logic [NR-1:0] exp_oh;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n = '{0, 0};
        set_client(0, rr_dvd[0], rr_dvs[0]);
        set_client(1, rr_dvd[1], rr_dvs[1]);
        req_valid = 2'b11;
        for (int c = 0; c < 80 && rk < 6; c++) begin
            tick();
            if (rsp_valid !== 2'b00) begin
                exp_oh = 2'b01 << (rk % 2);
                checks++;
                if ({rsp_valid, rsp_quotient} !== {exp_oh, DW'(rr_quo[rk])}) begin
                    errors++;
                    $display("FAIL rr_rsp%0d: rsp=%b q=%0d required %b/%0d", rk, rsp_valid, rsp_quotient, exp_oh, rr_quo[rk]);
                end
                rk++;
            end
            if (req_ready !== 2'b00 && gk < 6) begin
                exp_oh = 2'b01 << (gk % 2);
                checks++;
                if (req_ready !== exp_oh || dividend_tdata !== DW'(rr_dvd[gk])) begin
                    errors++;
                    $display("FAIL rr_grant%0d: ready=%b dvd=%0d required %b/%0d", gk, req_ready, dividend_tdata, exp_oh, rr_dvd[gk]);
                end
                g = req_ready[1] ? 1 : 0;
                n[g]++;
                if (n[g] < 3) set_client(g, rr_dvd[2*n[g]+g], rr_dvs[2*n[g]+g]);
                else req_valid[g] = 1'b0;
                gk++;
            end
        end
        checks++;
        if (gk != 6 || rk != 6 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL rr_counts: grants=%0d rsps=%0d outst=%0d required 6/6/0", gk, rk, outstanding);
        end
    endtask

    task automatic test_skewed();
        int rk = 0;
        divisor_tready  = 1'b1;
        dividend_tready = 1'b0;
        set_client(0, 40000, 13);
        set_client(1, 777, 7);
        req_valid = 2'b01;
        tick();
        checks++;
        if (req_ready !== 2'b01 || {divisor_tvalid, dividend_tvalid} !== 2'b11) begin
            errors++;
            $display("FAIL skew_grant: ready=%b tvalids=%b required 01/11", req_ready, {divisor_tvalid, dividend_tvalid});
        end
        req_valid = 2'b10;
        tick();
        checks++;
        if ({divisor_tvalid, dividend_tvalid} !== 2'b01) begin
            errors++;
            $display("FAIL skew_dvs_drop: tvalids=%b required 01", {divisor_tvalid, dividend_tvalid});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dividend_tvalid !== 1'b1 || dividend_tdata !== DW'(40000) || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL skew_hold%0d: tvalid=%b dvd=%0d ready=%b required 1/40000/00", i, dividend_tvalid, dividend_tdata, req_ready);
            end
        end
        dividend_tready = 1'b1;
        tick();
        checks++;
        if (dividend_tvalid !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL skew_dvd_drop: tvalid=%b ready=%b required 0/00", dividend_tvalid, req_ready);
        end
        tick();
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL skew_next_grant: ready=%b required 10", req_ready);
        end
        req_valid = 2'b00;
        for (int c = 0; c < 30 && rk < 2; c++) begin
            tick();
            if (rsp_valid !== 2'b00) begin
                checks++;
                if (rk == 0 && {rsp_valid, rsp_quotient} !== {2'b01, DW'(3076)}) begin
                    errors++;
                    $display("FAIL skew_rsp0: rsp=%b q=%0d required 01/3076", rsp_valid, rsp_quotient);
                end
                if (rk == 1 && {rsp_valid, rsp_quotient} !== {2'b10, DW'(111)}) begin
                    errors++;
                    $display("FAIL skew_rsp1: rsp=%b q=%0d required 10/111", rsp_valid, rsp_quotient);
                end
                rk++;
            end
        end
        checks++;
        if (rk != 2) begin
            errors++;
            $display("FAIL skew_rsp_count: got %0d required 2", rk);
        end
    endtask

    task automatic test_fifo_full();
        int grants = 0;
        int rsps = 0;
        int first_rsp_c = -1;
        int grant_c = -1;
        hold_results = 1'b1;
        set_client(0, 600, 6);
        set_client(1, 900, 3);
        req_valid = 2'b11;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (req_ready !== 2'b00) grants++;
        end
        checks++;
        if (grants != 8 || outstanding !== 4'd8 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL full_stall: grants=%0d outst=%0d ready=%b required 8/8/00", grants, outstanding, req_ready);
        end
        hold_results = 1'b0;
        for (int c = 0; c < 60 && rsps < 9; c++) begin
            tick();
            if (rsp_valid !== 2'b00) begin
                checks++;
                if (!((rsp_valid === 2'b01 && rsp_quotient === DW'(100)) ||
                      (rsp_valid === 2'b10 && rsp_quotient === DW'(300)))) begin
                    errors++;
                    $display("FAIL full_rsp%0d: rsp=%b q=%0d required 01/100 or 10/300", rsps, rsp_valid, rsp_quotient);
                end
                rsps++;
                if (first_rsp_c < 0) first_rsp_c = c;
            end
            if (req_ready !== 2'b00 && grant_c < 0) begin
                grant_c   = c;
                req_valid = 2'b00;
            end
        end
        checks++;
        if (first_rsp_c < 0 || grant_c != first_rsp_c + 1) begin
            errors++;
            $display("FAIL full_refill: grant at %0d first rsp at %0d required rsp+1", grant_c, first_rsp_c);
        end
        checks++;
        if (rsps != 9 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL full_drain: rsps=%0d outst=%0d required 9/0", rsps, outstanding);
        end
    endtask

    task automatic test_orphan();
        logic [NR-1:0] seen = '0;
        checks++;
        if (outstanding !== 4'd0 || err_orphan !== 1'b0) begin
            errors++;
            $display("FAIL orphan_pre: outst=%0d err=%b required 0/0", outstanding, err_orphan);
        end
        orphan_req++;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        checks++;
        if (seen !== 2'b00 || err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_set: rsp_seen=%b err=%b required 00/1", seen, err_orphan);
        end
        repeat (5) tick();
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_sticky: err=%b required 1", err_orphan);
        end
    endtask

    task automatic test_midflight_reset();
        int grants = 0;
        logic [NR-1:0] seen = '0;
        bit found = 0;
        hold_results = 1'b1;
        set_client(0, 100, 10);
        req_valid = 2'b01;
        for (int c = 0; c < 20 && grants < 3; c++) begin
            tick();
            if (req_ready !== 2'b00) grants++;
        end
        req_valid = 2'b00;
        repeat (2) tick();
        checks++;
        if (outstanding !== 4'd3) begin
            errors++;
            $display("FAIL mid_pre: outst=%0d required 3", outstanding);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        checks++;
        if (outstanding !== 4'd0 || {req_ready, divisor_tvalid, dividend_tvalid, rsp_valid, err_orphan} !== '0) begin
            errors++;
            $display("FAIL mid_reset: outst=%0d flags=%b required 0/0", outstanding,
                     {req_ready, divisor_tvalid, dividend_tvalid, rsp_valid, err_orphan});
        end
        hold_results = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen = seen | rsp_valid;
        end
        checks++;
        if (seen !== 2'b00) begin
            errors++;
            $display("FAIL mid_discard: rsp_seen=%b required 00", seen);
        end
        set_client(1, 2000, 16);
        req_valid = 2'b10;
        tick();
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL mid_regrant: ready=%b required 10", req_ready);
        end
        req_valid = 2'b00;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (rsp_valid !== 2'b00) found = 1;
        end
        checks++;
        if (!found || rsp_valid !== 2'b10 || rsp_quotient !== DW'(125) || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL mid_rsp: found=%0d rsp=%b q=%0d outst=%0d required 10/125/0", found, rsp_valid, rsp_quotient, outstanding);
        end
    endtask

    initial begin
        rstn            = 1'b0;
        req_valid       = '0;
        req_dividend    = '0;
        req_divisor     = '0;
        divisor_tready  = 1'b1;
        dividend_tready = 1'b1;
        hold_results    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_skewed();
        test_fifo_full();
        test_orphan();
        test_midflight_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
